// File: rtl/mem_port.sv
// Multicycle memory port: turns one-cycle MemRead/MemWrite strobes into a registered
// req/ack transaction against external word memory and stalls the control FSM meanwhile.
module mem_port #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IorD,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] Instr,
  output logic [31:0] MemData,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  o_dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic          r_iord;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_instr;
  logic [31:0]   r_mdata;
  logic          r_buserr;

  logic          w_strobe;
  logic [31:0]   w_addr;
  logic          w_misaligned;
  logic          w_timeout;

  assign w_strobe     = MemRead | MemWrite;
  assign w_addr       = IorD ? ALUOut : PC;
  assign w_misaligned = |w_addr[1:0];
  // r_cnt counts completed BUSY cycles; the TIMEOUT-th BUSY cycle without ack aborts.
  assign w_timeout    = (r_cnt == CW'(TIMEOUT - 1));

  // Handshake: mem_req is held high from the edge that enters BUSY until the edge
  // after mem_ack=1; mem_we/mem_addr/mem_wdata are stable for that whole window and
  // mem_ack is only looked at while mem_req is high.
  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign Instr       = r_instr;
  assign MemData     = r_mdata;
  assign BusErr      = r_buserr;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    Stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_strobe) begin
          Stall  = 1'b1;
          w_next = w_misaligned ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        Stall = 1'b1;
        if (mem_ack || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_iord   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_instr  <= '0;
      r_mdata  <= '0;
      r_buserr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            // Both strobes at once is a control bug: do the write, but flag it.
            if (MemRead && MemWrite) begin
              r_buserr <= 1'b1;
            end
            if (w_misaligned) begin
              r_buserr <= 1'b1;
            end else begin
              r_req   <= 1'b1;
              r_we    <= MemWrite;
              r_iord  <= IorD;
              r_addr  <= w_addr;
              r_wdata <= WriteData;
              r_cnt   <= '0;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            r_req <= 1'b0;
            if (!r_we) begin
              if (r_iord) begin
                r_mdata <= mem_rdata;
              end else begin
                r_instr <= mem_rdata;
              end
            end
          end else if (w_timeout) begin
            r_req    <= 1'b0;
            r_buserr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: fetch, load, store, back-to-back, timeout,
// misaligned, mid-transaction reset and write-priority scenarios.
module tb_mem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, IorD;
  logic [31:0] PC, ALUOut, WriteData;
  logic        Stall;
  logic [31:0] Instr, MemData;
  logic        BusErr, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  always #5 clk = ~clk;

  mem_port dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IorD       (IorD),
    .PC         (PC),
    .ALUOut     (ALUOut),
    .WriteData  (WriteData),
    .Stall      (Stall),
    .Instr      (Instr),
    .MemData    (MemData),
    .BusErr     (BusErr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .o_dbg_state(dbg_state)
  );

  // Observations filled in by drive_access.
  int          obs_stall, obs_busy, obs_done_at;
  logic        obs_req, obs_hold_ok, obs_we, obs_buserr;
  logic [31:0] obs_addr, obs_wdata, obs_instr, obs_mdata;

  // Acts as control FSM (strobes held until DONE) and as memory (ack after `waits` BUSY cycles).
  task automatic drive_access(input logic rd, input logic wr, input logic iord,
                              input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] wd, input logic give_ack,
                              input int waits, input logic [31:0] rdata);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; IorD = iord; PC = pc; ALUOut = alu; WriteData = wd;
    obs_stall = 0; obs_busy = 0; obs_done_at = -1;
    obs_req = 1'b0; obs_hold_ok = 1'b1; obs_we = 1'b0; obs_buserr = 1'b0;
    obs_addr = '0; obs_wdata = '0; obs_instr = '0; obs_mdata = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (Stall) obs_stall++;
      if (mem_req) begin
        if (!obs_req) begin
          obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata;
        end else if (mem_addr !== obs_addr || mem_we !== obs_we || mem_wdata !== obs_wdata) begin
          obs_hold_ok = 1'b0;
        end
        obs_req = 1'b1;
        if (give_ack && obs_busy == waits) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end
        obs_busy++;
      end
      if (dbg_state == ST_DONE) begin
        obs_done_at = c; obs_instr = Instr; obs_mdata = MemData; obs_buserr = BusErr;
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (obs_done_at >= 0) break;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0;
    PC = 32'h0; ALUOut = 32'h0; WriteData = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    n_vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL reset_req_we: got req=%b we=%b expected 0 0", mem_req, mem_we); end
    n_vec++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_addr_wdata: got %h %h expected 0 0", mem_addr, mem_wdata); end
    n_vec++; if (Instr !== 32'h0 || MemData !== 32'h0) begin n_err++; $display("FAIL reset_regs: got %h %h expected 0 0", Instr, MemData); end
    n_vec++; if (BusErr !== 1'b0 || Stall !== 1'b0) begin n_err++; $display("FAIL reset_flags: got buserr=%b stall=%b expected 0 0", BusErr, Stall); end
  endtask

  task automatic test_fetch();
    drive_access(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0300, 32'h0, 1'b1, 0, 32'h8C22_0004);
    n_vec++; if (obs_done_at !== 2) begin n_err++; $display("FAIL fetch_done_at: got %0d expected 2", obs_done_at); end
    n_vec++; if (obs_stall !== 2) begin n_err++; $display("FAIL fetch_stall: got %0d expected 2", obs_stall); end
    n_vec++; if (obs_addr !== 32'h40 || obs_we !== 1'b0) begin n_err++; $display("FAIL fetch_addr_we: got %h %b expected 00000040 0", obs_addr, obs_we); end
    n_vec++; if (obs_instr !== 32'h8C22_0004) begin n_err++; $display("FAIL fetch_instr: got %h expected 8c220004", obs_instr); end
    n_vec++; if (obs_mdata !== 32'h0) begin n_err++; $display("FAIL fetch_memdata: got %h expected 00000000", obs_mdata); end
  endtask

  task automatic test_load();
    drive_access(1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0000_0100, 32'h0, 1'b1, 3, 32'hDEAD_BEEF);
    n_vec++; if (obs_stall !== 5) begin n_err++; $display("FAIL load_stall: got %0d expected 5", obs_stall); end
    n_vec++; if (obs_busy !== 4 || obs_addr !== 32'h100) begin n_err++; $display("FAIL load_busy_addr: got %0d %h expected 4 00000100", obs_busy, obs_addr); end
    n_vec++; if (obs_mdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_memdata: got %h expected deadbeef", obs_mdata); end
    n_vec++; if (obs_instr !== 32'h8C22_0004) begin n_err++; $display("FAIL load_instr: got %h expected 8c220004", obs_instr); end
  endtask

  task automatic test_store();
    drive_access(1'b0, 1'b1, 1'b1, 32'h0000_0048, 32'h0000_0200, 32'h1234_5678, 1'b1, 2, 32'hFFFF_0000);
    n_vec++; if (obs_we !== 1'b1 || obs_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL store_we_wdata: got %b %h expected 1 12345678", obs_we, obs_wdata); end
    n_vec++; if (obs_hold_ok !== 1'b1 || obs_addr !== 32'h200) begin n_err++; $display("FAIL store_hold: got hold=%b addr=%h expected 1 00000200", obs_hold_ok, obs_addr); end
    n_vec++; if (obs_stall !== 4) begin n_err++; $display("FAIL store_stall: got %0d expected 4", obs_stall); end
    n_vec++; if (obs_instr !== 32'h8C22_0004 || obs_mdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_regs: got %h %h expected 8c220004 deadbeef", obs_instr, obs_mdata); end
    n_vec++; if (obs_buserr !== 1'b0) begin n_err++; $display("FAIL store_buserr: got %b expected 0", obs_buserr); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    MemRead = 1'b1; IorD = 1'b0; PC = 32'h0000_0050;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h50) begin n_err++; $display("FAIL b2b_req1: got %b %h expected 1 00000050", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
    @(negedge clk);
    mem_ack = 1'b0; #1;
    n_vec++; if (dbg_state !== ST_DONE || Stall !== 1'b0) begin n_err++; $display("FAIL b2b_done_gap: got state=%0d stall=%b expected 2 0", dbg_state, Stall); end
    n_vec++; if (Instr !== 32'hAAAA_0001) begin n_err++; $display("FAIL b2b_instr1: got %h expected aaaa0001", Instr); end
    @(negedge clk);
    PC = 32'h0000_0054; #1;
    n_vec++; if (dbg_state !== ST_IDLE || Stall !== 1'b1) begin n_err++; $display("FAIL b2b_reaccept: got state=%0d stall=%b expected 0 1", dbg_state, Stall); end
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h54) begin n_err++; $display("FAIL b2b_req2: got %b %h expected 1 00000054", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_0002;
    @(negedge clk);
    mem_ack = 1'b0; MemRead = 1'b0; #1;
    n_vec++; if (Instr !== 32'hAAAA_0002 || mem_req !== 1'b0) begin n_err++; $display("FAIL b2b_instr2: got %h req=%b expected aaaa0002 0", Instr, mem_req); end
  endtask

  task automatic test_timeout();
    drive_access(1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    n_vec++; if (obs_busy !== 15 || obs_done_at !== 16) begin n_err++; $display("FAIL timeout_len: got busy=%0d done_at=%0d expected 15 16", obs_busy, obs_done_at); end
    n_vec++; if (obs_stall !== 16) begin n_err++; $display("FAIL timeout_stall: got %0d expected 16", obs_stall); end
    n_vec++; if (obs_buserr !== 1'b1) begin n_err++; $display("FAIL timeout_buserr: got %b expected 1", obs_buserr); end
    n_vec++; if (obs_instr !== 32'hAAAA_0002) begin n_err++; $display("FAIL timeout_instr: got %h expected aaaa0002", obs_instr); end
    drive_access(1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'h0, 32'h0, 1'b1, 1, 32'h1111_2222);
    n_vec++; if (obs_buserr !== 1'b1 || obs_instr !== 32'h1111_2222) begin n_err++; $display("FAIL timeout_sticky: got buserr=%b instr=%h expected 1 11112222", obs_buserr, obs_instr); end
  endtask

  task automatic test_misaligned();
    drive_access(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0102, 32'h0, 1'b1, 0, 32'h5555_5555);
    n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL misaligned_req: got %b expected 0", obs_req); end
    n_vec++; if (obs_buserr !== 1'b1) begin n_err++; $display("FAIL misaligned_buserr: got %b expected 1", obs_buserr); end
    n_vec++; if (obs_done_at !== 1 || obs_stall !== 1) begin n_err++; $display("FAIL misaligned_timing: got done_at=%0d stall=%0d expected 1 1", obs_done_at, obs_stall); end
    n_vec++; if (obs_mdata !== 32'h0) begin n_err++; $display("FAIL misaligned_memdata: got %h expected 00000000", obs_mdata); end
  endtask

  task automatic test_reset_mid();
    drive_access(1'b1, 1'b0, 1'b0, 32'h0000_0070, 32'h0, 32'h0, 1'b1, 0, 32'h7777_0070);
    n_vec++; if (obs_instr !== 32'h7777_0070) begin n_err++; $display("FAIL rstmid_pre_instr: got %h expected 77770070", obs_instr); end
    @(negedge clk);
    MemRead = 1'b1; IorD = 1'b0; PC = 32'h0000_0074;
    @(negedge clk); #1;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rstmid_req: got %b expected 1", mem_req); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rstmid_async: got req=%b state=%0d expected 0 0", mem_req, dbg_state); end
    n_vec++; if (Instr !== 32'h0 || MemData !== 32'h0 || BusErr !== 1'b0 || mem_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_values: got %h %h %b %h expected 0 0 0 0", Instr, MemData, BusErr, mem_addr); end
    MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0; #1;
    n_vec++; if (Instr !== 32'h0 || mem_req !== 1'b0 || dbg_state !== ST_IDLE || Stall !== 1'b0) begin n_err++; $display("FAIL rstmid_late_ack: got instr=%h req=%b state=%0d stall=%b expected 0 0 0 0", Instr, mem_req, dbg_state, Stall); end
  endtask

  task automatic test_write_priority();
    drive_access(1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0300, 32'hCAFE_F00D, 1'b1, 0, 32'h9999_9999);
    n_vec++; if (obs_we !== 1'b1 || obs_wdata !== 32'hCAFE_F00D || obs_addr !== 32'h300) begin n_err++; $display("FAIL wprio_write: got we=%b wdata=%h addr=%h expected 1 cafef00d 00000300", obs_we, obs_wdata, obs_addr); end
    n_vec++; if (obs_buserr !== 1'b1) begin n_err++; $display("FAIL wprio_buserr: got %b expected 1", obs_buserr); end
    n_vec++; if (obs_instr !== 32'h0 || obs_mdata !== 32'h0) begin n_err++; $display("FAIL wprio_regs: got %h %h expected 0 0", obs_instr, obs_mdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout();
    apply_reset();
    test_misaligned();
    test_reset_mid();
    test_write_priority();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
